// File: rtl/nts_rx_buffer_pkg.sv
// -----------------------------------------------------------------------------
// nts_rx_buffer_pkg
// Shared definitions for the NTS engine receive buffer:
//   - state_t    : buffer FSM state encodings
//   - STAT_WIDTH : width of the wrapping statistics counters
// -----------------------------------------------------------------------------
package nts_rx_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_COPY    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam int STAT_WIDTH = 32;

endpackage

// File: rtl/nts_rx_buffer_ram.sv
// -----------------------------------------------------------------------------
// nts_rx_buffer_ram
// Simple dual-port word RAM holding one received packet.
//   i_clk                 : clock
//   i_wr_en/addr/data     : synchronous write port
//   i_rd_en/addr          : read request
//   o_rd_data             : read data, one cycle after i_rd_en
// Contents are never reset so the array maps onto block RAM.
// -----------------------------------------------------------------------------
module nts_rx_buffer_ram #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            rd_data_q <= mem[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/nts_rx_buffer.sv
// -----------------------------------------------------------------------------
// nts_rx_buffer
// Per-engine receive buffer behind the dispatcher. Claims a completed packet,
// drains the dispatcher FIFO into local RAM, releases the dispatcher slot and
// then holds the packet for random-access reads by the parser.
//   i_clk, i_areset               : clock, async active-high reset
//   o_dispatch_busy               : buffer not idle
//   i_dispatch_*/o_dispatch_*     : dispatcher claim / drain / release handshake
//   o_parser_packet_available     : packet held for the parser
//   o_parser_word_count/last_bytes: packet length information
//   i_parser_rd_en/addr           : read request, data one cycle later
//   o_parser_rd_valid/rd_data     : read response
//   i_parser_done                 : frees the buffer
//   o_stat_packets/o_stat_overflow: wrapping statistics
// -----------------------------------------------------------------------------
module nts_rx_buffer
    import nts_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    output logic                  o_dispatch_busy,
    input  logic                  i_dispatch_packet_available,
    input  logic                  i_dispatch_fifo_empty,
    input  logic [3:0]            i_dispatch_data_valid,
    output logic                  o_dispatch_fifo_rd_start,
    input  logic                  i_dispatch_fifo_rd_valid,
    input  logic [63:0]           i_dispatch_fifo_rd_data,
    output logic                  o_dispatch_packet_read_discard,
    output logic                  o_parser_packet_available,
    output logic [ADDR_WIDTH:0]   o_parser_word_count,
    output logic [3:0]            o_parser_last_bytes,
    input  logic                  i_parser_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_parser_rd_addr,
    output logic                  o_parser_rd_valid,
    output logic [63:0]           o_parser_rd_data,
    input  logic                  i_parser_done,
    output logic [STAT_WIDTH-1:0] o_stat_packets,
    output logic [STAT_WIDTH-1:0] o_stat_overflow
);

    state_t                state_q, state_d;
    // One bit wider than the RAM address so a full buffer is representable.
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic                  overflow_q, overflow_d;
    logic [3:0]            last_bytes_q, last_bytes_d;
    logic [STAT_WIDTH-1:0] stat_packets_q, stat_packets_d;
    logic [STAT_WIDTH-1:0] stat_overflow_q, stat_overflow_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  ram_we;
    logic                  rd_start;
    logic                  discard;
    logic [63:0]           ram_rd_data;

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        overflow_d      = overflow_q;
        last_bytes_d    = last_bytes_q;
        stat_packets_d  = stat_packets_q;
        stat_overflow_d = stat_overflow_q;
        ram_we          = 1'b0;
        rd_start        = 1'b0;
        discard         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
                    state_d    = ST_START;
                    wr_ptr_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_START: begin
                rd_start = 1'b1;
                state_d  = ST_COPY;
            end
            ST_COPY: begin
                // A word arriving together with empty is stored first; the
                // drain only ends on an empty sample with no word in flight.
                if (i_dispatch_fifo_rd_valid) begin
                    if (wr_ptr_q[ADDR_WIDTH]) begin
                        overflow_d = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
                    end
                end else if (i_dispatch_fifo_empty) begin
                    last_bytes_d = i_dispatch_data_valid;
                    state_d      = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                discard = 1'b1;
                if (overflow_q) begin
                    stat_overflow_d = stat_overflow_q + STAT_WIDTH'(1);
                    state_d         = ST_IDLE;
                end else if (wr_ptr_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    stat_packets_d = stat_packets_q + STAT_WIDTH'(1);
                    state_d        = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_parser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Parser reads are only honoured while a packet is held.
    assign rd_valid_d = i_parser_rd_en && (state_q == ST_HOLD);

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            overflow_q      <= 1'b0;
            last_bytes_q    <= '0;
            stat_packets_q  <= '0;
            stat_overflow_q <= '0;
            rd_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            overflow_q      <= overflow_d;
            last_bytes_q    <= last_bytes_d;
            stat_packets_q  <= stat_packets_d;
            stat_overflow_q <= stat_overflow_d;
            rd_valid_q      <= rd_valid_d;
        end
    end

    nts_rx_buffer_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (64)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (ram_we),
        .i_wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .i_wr_data (i_dispatch_fifo_rd_data),
        .i_rd_en   (rd_valid_d),
        .i_rd_addr (i_parser_rd_addr),
        .o_rd_data (ram_rd_data)
    );

    assign o_dispatch_busy                = (state_q != ST_IDLE);
    assign o_dispatch_fifo_rd_start       = rd_start;
    assign o_dispatch_packet_read_discard = discard;
    assign o_parser_packet_available      = (state_q == ST_HOLD);
    assign o_parser_word_count            = wr_ptr_q;
    assign o_parser_last_bytes            = last_bytes_q;
    assign o_parser_rd_valid              = rd_valid_q;
    // RAM output is not reset; mask it so idle/reset read data is zero.
    assign o_parser_rd_data               = rd_valid_q ? ram_rd_data : 64'd0;
    assign o_stat_packets                 = stat_packets_q;
    assign o_stat_overflow                = stat_overflow_q;

endmodule

// File: tb/tb_nts_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_nts_rx_buffer
// Two instances: index 0 with ADDR_WIDTH=7, index 1 with ADDR_WIDTH=3 for the
// fill/overflow cases. A dispatcher model per instance feeds packets whose
// words come from word_of(); table rows carry hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_nts_rx_buffer;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  pav    = '0;
    logic [1:0]  fempty = 2'b11;
    logic [1:0]  frv    = '0;
    logic [1:0]  prd_en = '0;
    logic [1:0]  pdone  = '0;
    logic [3:0]  dv     [2] = '{4'd0, 4'd0};
    logic [63:0] fdata  [2] = '{64'd0, 64'd0};
    logic [6:0]  raddr  [2] = '{7'd0, 7'd0};

    wire [1:0]  busy, rd_start, discard, avail, rdv;
    wire [7:0]  wc0;
    wire [3:0]  wc1;
    wire [3:0]  lb  [2];
    wire [63:0] rdd [2];
    wire [31:0] spk [2];
    wire [31:0] sov [2];

    nts_rx_buffer #(.ADDR_WIDTH(7)) dut0 (
        .i_clk(clk), .i_areset(areset),
        .o_dispatch_busy(busy[0]),
        .i_dispatch_packet_available(pav[0]),
        .i_dispatch_fifo_empty(fempty[0]),
        .i_dispatch_data_valid(dv[0]),
        .o_dispatch_fifo_rd_start(rd_start[0]),
        .i_dispatch_fifo_rd_valid(frv[0]),
        .i_dispatch_fifo_rd_data(fdata[0]),
        .o_dispatch_packet_read_discard(discard[0]),
        .o_parser_packet_available(avail[0]),
        .o_parser_word_count(wc0),
        .o_parser_last_bytes(lb[0]),
        .i_parser_rd_en(prd_en[0]),
        .i_parser_rd_addr(raddr[0]),
        .o_parser_rd_valid(rdv[0]),
        .o_parser_rd_data(rdd[0]),
        .i_parser_done(pdone[0]),
        .o_stat_packets(spk[0]),
        .o_stat_overflow(sov[0])
    );

    nts_rx_buffer #(.ADDR_WIDTH(3)) dut1 (
        .i_clk(clk), .i_areset(areset),
        .o_dispatch_busy(busy[1]),
        .i_dispatch_packet_available(pav[1]),
        .i_dispatch_fifo_empty(fempty[1]),
        .i_dispatch_data_valid(dv[1]),
        .o_dispatch_fifo_rd_start(rd_start[1]),
        .i_dispatch_fifo_rd_valid(frv[1]),
        .i_dispatch_fifo_rd_data(fdata[1]),
        .o_dispatch_packet_read_discard(discard[1]),
        .o_parser_packet_available(avail[1]),
        .o_parser_word_count(wc1),
        .o_parser_last_bytes(lb[1]),
        .i_parser_rd_en(prd_en[1]),
        .i_parser_rd_addr(raddr[1][2:0]),
        .o_parser_rd_valid(rdv[1]),
        .o_parser_rd_data(rdd[1]),
        .i_parser_done(pdone[1]),
        .o_stat_packets(spk[1]),
        .o_stat_overflow(sov[1])
    );

    // Pulse counters, sampled on the clock edge that ends each cycle.
    int nstart [2] = '{0, 0};
    int ndisc  [2] = '{0, 0};
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rd_start[s]) nstart[s] <= nstart[s] + 1;
            if (discard[s])  ndisc[s]  <= ndisc[s] + 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_wc(input int s);
        return (s == 0) ? wc0 : {4'd0, wc1};
    endfunction

    function automatic logic [63:0] word_of(input int seed, input int i);
        return {(32'(seed) * 32'h9E3779B1) ^ 32'(i), 32'hC0DE0000 | 32'(i)};
    endfunction

    task automatic offer(input int s, input logic [3:0] lbytes);
        @(negedge clk);
        pav[s]    = 1'b1;
        fempty[s] = 1'b0;
        dv[s]     = lbytes;
    endtask

    // Waits for rd_start; returns the number of cycles after the offer, or -1.
    task automatic wait_start(input int s, output int lat);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rd_start[s]) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rd_start timeout on dut%0d: got none, expected a pulse", s);
        end
    endtask

    // Called at the negedge where rd_start is visible. The last word comes
    // together with empty, exercising the store-then-terminate path.
    task automatic drain(input int s, input int n, input int seed);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            frv[s]    = 1'b1;
            fdata[s]  = word_of(seed, k);
            fempty[s] = (k == n - 1);
        end
        @(negedge clk);
        frv[s]    = 1'b0;
        fempty[s] = 1'b1;
        @(negedge clk);
        chk("discard_pulse", discard[s], 1'b1);
        pav[s] = 1'b0;
    endtask

    task automatic readback(input int s, input int n, input int seed);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("rd_valid@%0d", i - 1), rdv[s], 1'b1);
                chk($sformatf("rd_data@%0d", i - 1), rdd[s], word_of(seed, i - 1));
            end
            if (i < n) begin
                prd_en[s] = 1'b1;
                raddr[s]  = 7'(i);
            end else begin
                prd_en[s] = 1'b0;
            end
        end
    endtask

    task automatic release_buf(input int s);
        @(negedge clk);
        pdone[s] = 1'b1;
        @(negedge clk);
        pdone[s] = 1'b0;
        chk("avail_after_done", avail[s], 1'b0);
    endtask

    typedef struct {
        int         sel;
        int         nwords;
        logic [3:0] lbytes;
        int         seed;
        logic [7:0] exp_wc;
        logic       exp_avail;
        logic [31:0] exp_pk;
        logic [31:0] exp_ov;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat;
        int s0, d0;

        //       sel nw lb  seed  wc avail pk ov
        vecs[0] = '{0, 29, 4'd8, 1, 8'd29, 1'b1, 32'd1, 32'd0};
        vecs[1] = '{0,  6, 4'd4, 2, 8'd6,  1'b1, 32'd2, 32'd0};
        vecs[2] = '{1,  8, 4'd3, 3, 8'd8,  1'b1, 32'd1, 32'd0};
        vecs[3] = '{1, 12, 4'd8, 4, 8'd8,  1'b0, 32'd1, 32'd1};
        vecs[4] = '{0,  0, 4'd5, 5, 8'd0,  1'b0, 32'd2, 32'd0};
        vecs[5] = '{0,  1, 4'd1, 6, 8'd1,  1'b1, 32'd3, 32'd0};

        // Reset state.
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_busy", busy[s], 1'b0);
            chk("rst_rd_start", rd_start[s], 1'b0);
            chk("rst_discard", discard[s], 1'b0);
            chk("rst_avail", avail[s], 1'b0);
            chk("rst_wc", get_wc(s), 8'd0);
            chk("rst_lb", lb[s], 4'd0);
            chk("rst_rdv", rdv[s], 1'b0);
            chk("rst_rdd", rdd[s], 64'd0);
            chk("rst_spk", spk[s], 32'd0);
            chk("rst_sov", sov[s], 32'd0);
        end
        areset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            int s;
            s  = vecs[v].sel;
            s0 = nstart[s];
            d0 = ndisc[s];
            offer(s, vecs[v].lbytes);
            wait_start(s, lat);
            if (lat > 0) begin
                chk("claim_latency", 64'(lat), 64'd1);
                drain(s, vecs[v].nwords, vecs[v].seed);
                @(negedge clk);
                chk($sformatf("v%0d_avail", v), avail[s], vecs[v].exp_avail);
                chk($sformatf("v%0d_busy", v), busy[s], vecs[v].exp_avail);
                chk($sformatf("v%0d_wc", v), get_wc(s), vecs[v].exp_wc);
                chk($sformatf("v%0d_lb", v), lb[s], vecs[v].lbytes);
                chk($sformatf("v%0d_spk", v), spk[s], vecs[v].exp_pk);
                chk($sformatf("v%0d_sov", v), sov[s], vecs[v].exp_ov);
                chk($sformatf("v%0d_nstart", v), 64'(nstart[s] - s0), 64'd1);
                chk($sformatf("v%0d_ndisc", v), 64'(ndisc[s] - d0), 64'd1);
                if (vecs[v].exp_avail) begin
                    readback(s, vecs[v].nwords, vecs[v].seed);
                    release_buf(s);
                end
            end
        end

        // Second packet offered while holding is not claimed until done.
        offer(0, 4'd2);
        wait_start(0, lat);
        if (lat > 0) begin
            drain(0, 3, 7);
            @(negedge clk);
            chk("hold_spk1", spk[0], 32'd4);
            s0 = nstart[0];
            offer(0, 4'd6);
            repeat (4) @(negedge clk);
            chk("hold_no_start", 64'(nstart[0] - s0), 64'd0);
            chk("hold_busy", busy[0], 1'b1);
            chk("hold_avail", avail[0], 1'b1);
            pdone[0] = 1'b1;
            @(negedge clk);
            pdone[0] = 1'b0;
            chk("done_avail", avail[0], 1'b0);
            chk("done_no_start_yet", rd_start[0], 1'b0);
            @(negedge clk);
            chk("done_rd_start", rd_start[0], 1'b1);
            if (rd_start[0]) begin
                drain(0, 4, 8);
                @(negedge clk);
                chk("hold2_avail", avail[0], 1'b1);
                chk("hold2_wc", get_wc(0), 8'd4);
                chk("hold2_lb", lb[0], 4'd6);
                chk("hold2_spk", spk[0], 32'd5);
                readback(0, 4, 8);
                release_buf(0);
            end
        end

        // Read request while idle is ignored.
        @(negedge clk);
        prd_en[0] = 1'b1;
        raddr[0]  = 7'd0;
        @(negedge clk);
        prd_en[0] = 1'b0;
        chk("idle_rd_valid", rdv[0], 1'b0);
        chk("idle_rd_data", rdd[0], 64'd0);

        // Reset in the middle of a copy.
        d0 = ndisc[0];
        offer(0, 4'd8);
        wait_start(0, lat);
        if (lat > 0) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                frv[0]   = 1'b1;
                fdata[0] = word_of(9, k);
            end
            @(negedge clk);
            frv[0]    = 1'b0;
            areset    = 1'b1;
            pav[0]    = 1'b0;
            fempty[0] = 1'b1;
            @(negedge clk);
            chk("mid_rst_busy", busy[0], 1'b0);
            chk("mid_rst_discard", discard[0], 1'b0);
            chk("mid_rst_avail", avail[0], 1'b0);
            chk("mid_rst_wc", get_wc(0), 8'd0);
            chk("mid_rst_lb", lb[0], 4'd0);
            chk("mid_rst_spk", spk[0], 32'd0);
            chk("mid_rst_rdv", rdv[0], 1'b0);
            chk("mid_rst_ndisc", 64'(ndisc[0] - d0), 64'd0);
            areset = 1'b0;
            offer(0, 4'd2);
            wait_start(0, lat);
            if (lat > 0) begin
                chk("post_rst_latency", 64'(lat), 64'd1);
                drain(0, 5, 10);
                @(negedge clk);
                chk("post_rst_avail", avail[0], 1'b1);
                chk("post_rst_wc", get_wc(0), 8'd5);
                chk("post_rst_lb", lb[0], 4'd2);
                chk("post_rst_spk", spk[0], 32'd1);
                readback(0, 5, 10);
                release_buf(0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
